// File: rtl/puf_pkg.sv
// Shared types and helpers for the PUF measurement sequencer.
//   puf_seq_state_t : sequencer FSM states
//   DEF_CHAL_W/DEF_RESP_W : default challenge/response widths
//   cnt_width()     : counter width able to hold 0..max_val
package puf_pkg;

  localparam int unsigned DEF_CHAL_W = 8;
  localparam int unsigned DEF_RESP_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    RESET_PUF,
    SETTLE,
    RUN,
    CAPTURE,
    RESULT
  } puf_seq_state_t;

  // Bits needed to count from 0 up to and including max_val (minimum 1).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    if (max_val < 32'd2) return 32'd1;
    return 32'($clog2(max_val + 32'd1));
  endfunction

endpackage

// File: rtl/puf_sequencer_if.sv
// Host request/response channel of the PUF sequencer.
//   req_valid/req_ready/req_challenge : challenge request handshake
//   rsp_valid/rsp_ready              : result handshake
//   rsp_response/rsp_unstable/rsp_error : voted result, per-bit disagreement, timeout flag
// master = host side, slave = sequencer side.
interface puf_sequencer_if #(
  parameter int unsigned CHAL_W = 8,
  parameter int unsigned RESP_W = 8
) ();

  logic              req_valid;
  logic              req_ready;
  logic [CHAL_W-1:0] req_challenge;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [RESP_W-1:0] rsp_response;
  logic [RESP_W-1:0] rsp_unstable;
  logic              rsp_error;

  modport master (
    output req_valid, req_challenge, rsp_ready,
    input  req_ready, rsp_valid, rsp_response, rsp_unstable, rsp_error
  );

  modport slave (
    input  req_valid, req_challenge, rsp_ready,
    output req_ready, rsp_valid, rsp_response, rsp_unstable, rsp_error
  );

endinterface

// File: rtl/puf_vote_accum.sv
// Per-bit ones counters for majority voting over repeated PUF measurements.
//   clear      : zero counters and result outputs
//   accumulate : add bits_in into the counters this cycle
//   finalize   : register majority/unstable, including this cycle's accumulate
//   majority   : bit set when more than half the votes were 1
//   unstable   : bit set when the votes for that bit were not unanimous
module puf_vote_accum
  import puf_pkg::*;
#(
  parameter int unsigned RESP_W    = DEF_RESP_W,
  parameter int unsigned NUM_VOTES = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              accumulate,
  input  logic              finalize,
  input  logic [RESP_W-1:0] bits_in,
  output logic [RESP_W-1:0] majority,
  output logic [RESP_W-1:0] unstable
);

  localparam int unsigned CNT_W = cnt_width(NUM_VOTES);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(NUM_VOTES / 2);
  localparam logic [CNT_W-1:0] ALL  = CNT_W'(NUM_VOTES);

  logic [CNT_W-1:0]  ones_q [RESP_W];
  logic [CNT_W-1:0]  ones_n [RESP_W];
  logic [RESP_W-1:0] maj_n;
  logic [RESP_W-1:0] unst_n;

  // Next counter values; the verdict looks at them so finalize can share a cycle with the last add.
  always_comb begin
    maj_n  = '0;
    unst_n = '0;
    for (int b = 0; b < int'(RESP_W); b++) begin
      ones_n[b] = ones_q[b];
      if (clear) begin
        ones_n[b] = '0;
      end else if (accumulate) begin
        ones_n[b] = ones_q[b] + CNT_W'(bits_in[b]);
      end
      maj_n[b]  = (ones_n[b] > HALF);
      unst_n[b] = (ones_n[b] != '0) && (ones_n[b] != ALL);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < int'(RESP_W); b++) ones_q[b] <= '0;
      majority <= '0;
      unstable <= '0;
    end else begin
      for (int b = 0; b < int'(RESP_W); b++) ones_q[b] <= ones_n[b];
      if (clear) begin
        majority <= '0;
        unstable <= '0;
      end else if (finalize) begin
        majority <= maj_n;
        unstable <= unst_n;
      end
    end
  end

endmodule

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single-bit asynchronous input.
//   clk, reset : destination clock, async active-high reset (output resets to 0)
//   d          : asynchronous input
//   q          : synchronized output, two clk cycles of latency
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/puf_sequencer.sv
// Sequences the ring-oscillator PUF for one challenge: per vote it resets the PUF,
// lets it settle, runs the oscillators until done (or timeout) and captures the
// response; after NUM_VOTES votes it reports the per-bit majority.
//   clk, reset    : system clock, async active-high reset
//   host          : request/response channel (slave side)
//   busy          : sequencer not idle
//   puf_enable    : oscillator/counter enable to the PUF
//   puf_challenge : challenge held for the whole request
//   puf_reset     : PUF counter/arbiter reset
//   puf_done      : PUF all-done, asynchronous to clk
//   puf_response  : PUF response, stable while puf_done is high
module puf_sequencer
  import puf_pkg::*;
#(
  parameter int unsigned CHAL_W      = DEF_CHAL_W,
  parameter int unsigned RESP_W      = DEF_RESP_W,
  parameter int unsigned NUM_VOTES   = 5,
  parameter int unsigned RST_CYC     = 4,
  parameter int unsigned SETTLE_CYC  = 2,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic              clk,
  input  logic              reset,
  puf_sequencer_if.slave    host,
  output logic              busy,
  output logic              puf_enable,
  output logic [CHAL_W-1:0] puf_challenge,
  output logic              puf_reset,
  input  logic              puf_done,
  input  logic [RESP_W-1:0] puf_response
);

  localparam int unsigned MAX_PHASE = (RST_CYC > SETTLE_CYC) ? RST_CYC : SETTLE_CYC;
  localparam int unsigned VOTE_W    = cnt_width(NUM_VOTES);
  localparam int unsigned CYC_W     = cnt_width(MAX_PHASE);
  localparam int unsigned TMO_W     = cnt_width(TIMEOUT_CYC);

  puf_seq_state_t    state_q, state_n;
  logic [CYC_W-1:0]  cyc_q, cyc_n;
  logic [TMO_W-1:0]  tmo_q, tmo_n;
  logic [VOTE_W-1:0] vote_q, vote_n;
  logic [CHAL_W-1:0] chal_n;
  logic              rsp_valid_q, rsp_valid_n;
  logic              rsp_error_q, rsp_error_n;
  logic              req_ready_q;
  logic              done_s;
  logic              acc_clear, acc_add, acc_final;
  logic [RESP_W-1:0] majority, unstable;

  sync_2ff u_done_sync (
    .clk   (clk),
    .reset (reset),
    .d     (puf_done),
    .q     (done_s)
  );

  puf_vote_accum #(
    .RESP_W    (RESP_W),
    .NUM_VOTES (NUM_VOTES)
  ) u_accum (
    .clk        (clk),
    .reset      (reset),
    .clear      (acc_clear),
    .accumulate (acc_add),
    .finalize   (acc_final),
    .bits_in    (puf_response),
    .majority   (majority),
    .unstable   (unstable)
  );

  // Next-state and datapath control.
  always_comb begin
    state_n     = state_q;
    cyc_n       = cyc_q;
    tmo_n       = tmo_q;
    vote_n      = vote_q;
    chal_n      = puf_challenge;
    rsp_valid_n = rsp_valid_q;
    rsp_error_n = rsp_error_q;
    acc_clear   = 1'b0;
    acc_add     = 1'b0;
    acc_final   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (host.req_valid) begin
          chal_n      = host.req_challenge;
          vote_n      = '0;
          cyc_n       = '0;
          rsp_error_n = 1'b0;
          acc_clear   = 1'b1;
          state_n     = RESET_PUF;
        end
      end

      RESET_PUF: begin
        if (cyc_q == CYC_W'(RST_CYC - 1)) begin
          cyc_n   = '0;
          state_n = SETTLE;
        end else begin
          cyc_n = cyc_q + CYC_W'(1);
        end
      end

      SETTLE: begin
        if (cyc_q == CYC_W'(SETTLE_CYC - 1)) begin
          cyc_n   = '0;
          tmo_n   = '0;
          state_n = RUN;
        end else begin
          cyc_n = cyc_q + CYC_W'(1);
        end
      end

      RUN: begin
        // A done seen in the last allowed cycle still wins over the timeout.
        if (done_s) begin
          state_n = CAPTURE;
        end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
          rsp_error_n = 1'b1;
          rsp_valid_n = 1'b1;
          acc_clear   = 1'b1;
          state_n     = RESULT;
        end else begin
          tmo_n = tmo_q + TMO_W'(1);
        end
      end

      CAPTURE: begin
        acc_add = 1'b1;
        vote_n  = vote_q + VOTE_W'(1);
        if (vote_q == VOTE_W'(NUM_VOTES - 1)) begin
          acc_final   = 1'b1;
          rsp_valid_n = 1'b1;
          state_n     = RESULT;
        end else begin
          cyc_n   = '0;
          state_n = RESET_PUF;
        end
      end

      RESULT: begin
        if (host.rsp_ready) begin
          rsp_valid_n = 1'b0;
          state_n     = IDLE;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  // State, counters and registered outputs decoded from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cyc_q         <= '0;
      tmo_q         <= '0;
      vote_q        <= '0;
      puf_challenge <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_error_q   <= 1'b0;
      req_ready_q   <= 1'b1;
      busy          <= 1'b0;
      puf_reset     <= 1'b1;
      puf_enable    <= 1'b0;
    end else begin
      state_q       <= state_n;
      cyc_q         <= cyc_n;
      tmo_q         <= tmo_n;
      vote_q        <= vote_n;
      puf_challenge <= chal_n;
      rsp_valid_q   <= rsp_valid_n;
      rsp_error_q   <= rsp_error_n;
      req_ready_q   <= (state_n == IDLE);
      busy          <= (state_n != IDLE);
      puf_reset     <= (state_n == IDLE) || (state_n == RESET_PUF) || (state_n == RESULT);
      puf_enable    <= (state_n == RUN);
    end
  end

  assign host.req_ready    = req_ready_q;
  assign host.rsp_valid    = rsp_valid_q;
  assign host.rsp_error    = rsp_error_q;
  assign host.rsp_response = majority;
  assign host.rsp_unstable = unstable;

endmodule

// File: tb/tb_puf_sequencer.sv
// Directed bench for puf_sequencer with a behavioural ring-oscillator PUF model.
module tb_puf_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       busy;
  logic       puf_enable;
  logic       puf_reset;
  logic [7:0] puf_challenge;
  logic       puf_done = 1'b0;
  logic [7:0] puf_response = 8'h00;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int pulses = 0;
  int en_high = 0;
  logic en_prev = 1'b0;

  // PUF model: done rises on the model_delay-th falling edge with enable high (0 = never).
  int         model_delay = 0;
  int         model_vote  = 0;
  int         en_cnt      = 0;
  logic [7:0] model_resp [5];

  always #5 clk = ~clk;

  puf_sequencer_if #(.CHAL_W(8), .RESP_W(8)) bus ();

  puf_sequencer #(
    .CHAL_W      (8),
    .RESP_W      (8),
    .NUM_VOTES   (5),
    .RST_CYC     (4),
    .SETTLE_CYC  (2),
    .TIMEOUT_CYC (50)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .host          (bus),
    .busy          (busy),
    .puf_enable    (puf_enable),
    .puf_challenge (puf_challenge),
    .puf_reset     (puf_reset),
    .puf_done      (puf_done),
    .puf_response  (puf_response)
  );

  always @(negedge clk) begin
    if (puf_enable) begin
      en_cnt = en_cnt + 1;
      if (model_delay != 0 && en_cnt == model_delay) begin
        puf_response = model_resp[model_vote];
        puf_done     = 1'b1;
        model_vote   = (model_vote + 1) % 5;
      end
    end else begin
      en_cnt   = 0;
      puf_done = 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (puf_enable && !en_prev) pulses++;
    if (puf_enable) en_high++;
    en_prev = puf_enable;
  endtask

  task automatic set_model(input int d, input logic [7:0] r0, r1, r2, r3, r4);
    model_delay   = d;
    model_vote    = 0;
    model_resp[0] = r0;
    model_resp[1] = r1;
    model_resp[2] = r2;
    model_resp[3] = r3;
    model_resp[4] = r4;
  endtask

  // Present a request and return just after the accepting edge.
  task automatic send_req(input logic [7:0] chal);
    int n;
    n = 0;
    bus.req_valid     = 1'b1;
    bus.req_challenge = chal;
    while (!bus.req_ready && n < 200) begin
      step();
      n++;
    end
    check("req_ready_wait", 32'(bus.req_ready), 32'd1);
    step();
    bus.req_valid = 1'b0;
    pulses  = 0;
    en_high = 0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!bus.rsp_valid && lat < 3000) begin
      step();
      lat++;
    end
    check("rsp_valid_wait", 32'(bus.rsp_valid), 32'd1);
  endtask

  initial begin
    int   lat;
    logic ok;

    reset             = 1'b1;
    bus.req_valid     = 1'b0;
    bus.req_challenge = 8'h00;
    bus.rsp_ready     = 1'b1;
    set_model(20, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5);
    step();
    step();

    // Reset values
    check("rst_puf_reset", 32'(puf_reset), 32'd1);
    check("rst_puf_enable", 32'(puf_enable), 32'd0);
    check("rst_puf_chal", 32'(puf_challenge), 32'h0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_resp", 32'(bus.rsp_response), 32'h0);
    check("rst_rsp_unst", 32'(bus.rsp_unstable), 32'h0);
    check("rst_rsp_err", 32'(bus.rsp_error), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    step();
    step();

    // Basic: constant response, latency 5 x (4+2+20+2+1) = 145
    send_req(8'h3C);
    check("basic_chal", 32'(puf_challenge), 32'h3C);
    check("basic_busy", 32'(busy), 32'd1);
    check("basic_req_ready", 32'(bus.req_ready), 32'd0);
    wait_rsp(lat);
    check("basic_latency", 32'(lat), 32'd145);
    check("basic_resp", 32'(bus.rsp_response), 32'hA5);
    check("basic_unst", 32'(bus.rsp_unstable), 32'h00);
    check("basic_err", 32'(bus.rsp_error), 32'd0);
    check("basic_pulses", 32'(pulses), 32'd5);
    check("basic_result_reset", 32'(puf_reset), 32'd1);
    check("basic_result_chal", 32'(puf_challenge), 32'h3C);
    step();
    check("basic_rsp_drop", 32'(bus.rsp_valid), 32'd0);
    check("basic_idle_ready", 32'(bus.req_ready), 32'd1);

    // Majority: bits 7:4 get 3 ones, bits 3:0 get 4 ones out of 5
    set_model(20, 8'hFF, 8'h0F, 8'hFF, 8'h00, 8'hFF);
    send_req(8'h11);
    wait_rsp(lat);
    check("maj_resp", 32'(bus.rsp_response), 32'hFF);
    check("maj_unst", 32'(bus.rsp_unstable), 32'hFF);
    check("maj_err", 32'(bus.rsp_error), 32'd0);
    step();

    // Timeout: done never rises
    set_model(0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    send_req(8'h77);
    wait_rsp(lat);
    check("tmo_err", 32'(bus.rsp_error), 32'd1);
    check("tmo_resp", 32'(bus.rsp_response), 32'h00);
    check("tmo_unst", 32'(bus.rsp_unstable), 32'h00);
    check("tmo_en_cycles", 32'(en_high), 32'd50);
    check("tmo_pulses", 32'(pulses), 32'd1);
    step();
    check("tmo_err_held", 32'(bus.rsp_error), 32'd1);

    // Normal request after a timeout clears the error
    set_model(20, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5);
    send_req(8'h78);
    check("post_tmo_err_clr", 32'(bus.rsp_error), 32'd0);
    wait_rsp(lat);
    check("post_tmo_err", 32'(bus.rsp_error), 32'd0);
    check("post_tmo_resp", 32'(bus.rsp_response), 32'hA5);
    step();

    // Backpressure with a pending second request
    set_model(5, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h3C);
    send_req(8'h01);
    wait_rsp(lat);
    bus.rsp_ready     = 1'b0;
    bus.req_valid     = 1'b1;
    bus.req_challenge = 8'h02;
    ok = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step();
      if (!bus.rsp_valid || bus.rsp_response !== 8'h3C || bus.rsp_unstable !== 8'h00 ||
          bus.req_ready || puf_challenge !== 8'h01 || puf_enable)
        ok = 1'b0;
    end
    check("bp_stable", 32'(ok), 32'd1);
    check("bp_req_ready", 32'(bus.req_ready), 32'd0);
    bus.rsp_ready = 1'b1;
    step();
    check("bp_rsp_drop", 32'(bus.rsp_valid), 32'd0);
    check("bp_ready_next", 32'(bus.req_ready), 32'd1);
    step();
    bus.req_valid = 1'b0;
    pulses  = 0;
    en_high = 0;
    check("bp_second_busy", 32'(busy), 32'd1);
    check("bp_second_chal", 32'(puf_challenge), 32'h02);
    wait_rsp(lat);
    check("bp_second_resp", 32'(bus.rsp_response), 32'h3C);
    step();

    // Reset during the third vote's RUN phase
    set_model(20, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5);
    send_req(8'h55);
    lat = 0;
    while (!(pulses == 3 && puf_enable) && lat < 500) begin
      step();
      lat++;
    end
    check("mid_reach_vote3", 32'(pulses), 32'd3);
    reset = 1'b1;
    #1;
    check("mid_enable", 32'(puf_enable), 32'd0);
    check("mid_puf_reset", 32'(puf_reset), 32'd1);
    check("mid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("mid_chal", 32'(puf_challenge), 32'h00);
    step();
    step();
    reset = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 300; i++) begin
      step();
      if (bus.rsp_valid || busy || puf_enable) ok = 1'b0;
    end
    check("mid_no_stale", 32'(ok), 32'd1);
    check("mid_ready", 32'(bus.req_ready), 32'd1);

    // done_s rises in the final allowed RUN cycle: capture wins
    set_model(48, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A);
    send_req(8'h99);
    wait_rsp(lat);
    check("edge_err", 32'(bus.rsp_error), 32'd0);
    check("edge_resp", 32'(bus.rsp_response), 32'h5A);
    check("edge_pulses", 32'(pulses), 32'd5);
    step();

    // One cycle later than that is a timeout
    set_model(49, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A);
    send_req(8'h9A);
    wait_rsp(lat);
    check("late_err", 32'(bus.rsp_error), 32'd1);
    check("late_resp", 32'(bus.rsp_response), 32'h00);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
